tlc5955_rx: RTL and testbench

TLC5955_RX -- requirements
Module: tlc5955_rx

---
 rtl/tlc5955_pkg.sv | 45 ++++
 rtl/tlc5955_if.sv | 11 +
 rtl/tlc5955_sync_edge.sv | 44 ++++
 rtl/tlc5955_rx.sv | 163 ++++++++++++++++
 tb/tb_tlc5955_rx.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tlc5955_pkg.sv
// Shared TLC5955 definitions: frame geometry, control-frame field map and
// receiver FSM states. The writer side uses the same package.
package tlc5955_pkg;

  localparam int FRAME_LEN = 769;
  localparam int SR_W      = FRAME_LEN;
  localparam int GS_W      = 768;
  localparam int NUM_CH    = 48;
  localparam int GS_CH_W   = 16;
  localparam int CNT_W     = 11;

  localparam int MODE_BIT  = 768;
  localparam int HDR_MSB   = 767;
  localparam int HDR_LSB   = 760;
  localparam logic [7:0] CTRL_HEADER = 8'h96;

  localparam int FC_MSB = 370;
  localparam int FC_LSB = 366;
  localparam int BC_MSB = 365;
  localparam int BC_LSB = 345;
  localparam int MC_MSB = 344;
  localparam int MC_LSB = 336;
  localparam int DC_MSB = 335;
  localparam int DC_LSB = 0;
  localparam int CTRL_W = FC_MSB - DC_LSB + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_DECODE = 2'd2
  } rx_state_e;

  // Packed in the same order as the frame bits, so a straight slice casts in.
  typedef struct packed {
    logic [FC_MSB-FC_LSB:0] fc;
    logic [BC_MSB-BC_LSB:0] bc;
    logic [MC_MSB-MC_LSB:0] mc;
    logic [DC_MSB-DC_LSB:0] dc;
  } ctrl_fields_t;

  function automatic ctrl_fields_t extract_ctrl(input logic [SR_W-1:0] sr);
    return ctrl_fields_t'(sr[FC_MSB:DC_LSB]);
  endfunction

endpackage

// File: rtl/tlc5955_if.sv
// Serial bus between an LED-driver writer (master) and a TLC5955 receiver
// (slave); SOUT is the daisy-chain return.
interface tlc5955_if;
  logic SCLK;
  logic SIN;
  logic LAT;
  logic SOUT;

  modport master (output SCLK, output SIN, output LAT, input SOUT);
  modport slave  (input SCLK, input SIN, input LAT, output SOUT);
endinterface

// File: rtl/tlc5955_sync_edge.sv
// Multi-flop synchronizer with rising-edge detect for one asynchronous input.
// Edge detection is held off until the chain has refilled after reset.
module tlc5955_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic spiClk,
  input  logic nReset,
  input  logic d,
  output logic q,
  output logic rise
);

  localparam logic [2:0] SETTLE_DONE = 3'(STAGES + 1);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;
  logic [2:0]        settle_q, settle_d;
  logic              armed;

  // A line already high at reset release ripples in as 0->1; 'armed' masks it.
  assign armed = (settle_q == SETTLE_DONE);

  always_comb begin
    sync_d   = {sync_q[STAGES-2:0], d};
    prev_d   = sync_q[STAGES-1];
    settle_d = armed ? settle_q : settle_q + 3'd1;
  end

  always_ff @(posedge spiClk) begin
    if (!nReset) begin
      sync_q   <= '0;
      prev_q   <= 1'b0;
      settle_q <= 3'd0;
    end else begin
      sync_q   <= sync_d;
      prev_q   <= prev_d;
      settle_q <= settle_d;
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = armed & sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/tlc5955_rx.sv
// TLC5955 serial receiver: shifts the 769-bit frame, decodes on LAT into
// control fields (with double-write confirmation) or the grayscale store.
module tlc5955_rx
  import tlc5955_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                 spiClk,
  input  logic                 nReset,
  tlc5955_if.slave             ser,
  output logic [4:0]           fcOut,
  output logic [20:0]          bcOut,
  output logic [8:0]           mcOut,
  output logic [335:0]         dcOut,
  output logic                 ctrlValid,
  output logic                 ctrlMismatch,
  output logic                 gsStrobe,
  input  logic [5:0]           gsAddr,
  output logic [GS_CH_W-1:0]   gsData,
  output logic                 shortFrame
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Synchronizers: index 0 = SCLK, 1 = SIN, 2 = LAT
  logic [2:0] raw_in, sync_lvl, sync_rise;
  logic       sync_unused;
  logic       sclk_rise, lat_rise, sin_sync;

  assign raw_in = {ser.LAT, ser.SIN, ser.SCLK};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      tlc5955_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
        .spiClk (spiClk),
        .nReset (nReset),
        .d      (raw_in[gi]),
        .q      (sync_lvl[gi]),
        .rise   (sync_rise[gi])
      );
    end
  endgenerate

  assign sclk_rise   = sync_rise[0];
  assign lat_rise    = sync_rise[2];
  assign sin_sync    = sync_lvl[1];
  assign sync_unused = &{sync_lvl[0], sync_lvl[2], sync_rise[1]};

  rx_state_e          state_q, state_d;
  logic [SR_W-1:0]    sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sout_q, sout_d;
  logic [GS_W-1:0]    gs_q, gs_d;
  logic [GS_CH_W-1:0] gs_data_q, gs_data_d;
  ctrl_fields_t       ctrl_q, ctrl_d;
  logic               have_ctrl_q, have_ctrl_d;
  logic               valid_q, valid_d;
  logic               mism_q, mism_d;
  logic               short_q, short_d;
  logic               gs_strobe_q, gs_strobe_d;
  ctrl_fields_t       frame_ctrl;

  assign frame_ctrl = extract_ctrl(sr_q);

  always_ff @(posedge spiClk) begin
    if (!nReset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (lat_rise) state_d = ST_DECODE;
                 else if (sclk_rise) state_d = ST_SHIFT;
      ST_SHIFT:  if (lat_rise) state_d = ST_DECODE;
      ST_DECODE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // ctrl_q is both the shadow copy and the output copy: they always update together.
  always_comb begin
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    sout_d      = sout_q;
    gs_d        = gs_q;
    ctrl_d      = ctrl_q;
    have_ctrl_d = have_ctrl_q;
    valid_d     = valid_q;
    mism_d      = mism_q;
    short_d     = short_q;
    gs_strobe_d = 1'b0;

    if (sclk_rise) begin
      sr_d   = {sr_q[SR_W-2:0], sin_sync};
      sout_d = sr_q[SR_W-2];
      cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end

    if (state_q == ST_DECODE) begin
      cnt_d = {{(CNT_W-1){1'b0}}, sclk_rise};
      if (cnt_q < CNT_W'(FRAME_LEN)) begin
        short_d = 1'b1;
      end else if (!sr_q[MODE_BIT]) begin
        gs_d        = sr_q[GS_W-1:0];
        gs_strobe_d = 1'b1;
      end else if (sr_q[HDR_MSB:HDR_LSB] == CTRL_HEADER) begin
        if (!have_ctrl_q) begin
          ctrl_d      = frame_ctrl;
          have_ctrl_d = 1'b1;
        end else if (frame_ctrl == ctrl_q) begin
          valid_d = 1'b1;
        end else begin
          ctrl_d  = frame_ctrl;
          mism_d  = 1'b1;
          valid_d = 1'b0;
        end
      end
    end

    gs_data_d = (gsAddr < 6'(NUM_CH)) ? gs_q[{gsAddr, 4'b0000} +: GS_CH_W] : '0;
  end

  always_ff @(posedge spiClk) begin
    if (!nReset) begin
      sr_q        <= '0;
      cnt_q       <= '0;
      sout_q      <= 1'b0;
      gs_q        <= '0;
      gs_data_q   <= '0;
      ctrl_q      <= '0;
      have_ctrl_q <= 1'b0;
      valid_q     <= 1'b0;
      mism_q      <= 1'b0;
      short_q     <= 1'b0;
      gs_strobe_q <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      sout_q      <= sout_d;
      gs_q        <= gs_d;
      gs_data_q   <= gs_data_d;
      ctrl_q      <= ctrl_d;
      have_ctrl_q <= have_ctrl_d;
      valid_q     <= valid_d;
      mism_q      <= mism_d;
      short_q     <= short_d;
      gs_strobe_q <= gs_strobe_d;
    end
  end

  assign ser.SOUT    = sout_q;
  assign fcOut       = ctrl_q.fc;
  assign bcOut       = ctrl_q.bc;
  assign mcOut       = ctrl_q.mc;
  assign dcOut       = ctrl_q.dc;
  assign ctrlValid   = valid_q;
  assign ctrlMismatch = mism_q;
  assign gsStrobe    = gs_strobe_q;
  assign gsData      = gs_data_q;
  assign shortFrame  = short_q;

endmodule

// File: tb/tb_tlc5955_rx.sv
// Scoreboard bench for tlc5955_rx: stimulus queues the expected post-LAT state,
// a monitor observes the DUT after each LAT and compares.
module tb_tlc5955_rx;

  logic         spiClk = 1'b0;
  logic         nReset = 1'b0;
  logic [4:0]   fcOut;
  logic [20:0]  bcOut;
  logic [8:0]   mcOut;
  logic [335:0] dcOut;
  logic         ctrlValid, ctrlMismatch, gsStrobe, shortFrame;
  logic [5:0]   gsAddr;
  logic [15:0]  gsData;

  always #5 spiClk = ~spiClk;

  tlc5955_if ser ();

  tlc5955_rx #(.SYNC_STAGES(2)) dut (
    .spiClk       (spiClk),
    .nReset       (nReset),
    .ser          (ser),
    .fcOut        (fcOut),
    .bcOut        (bcOut),
    .mcOut        (mcOut),
    .dcOut        (dcOut),
    .ctrlValid    (ctrlValid),
    .ctrlMismatch (ctrlMismatch),
    .gsStrobe     (gsStrobe),
    .gsAddr       (gsAddr),
    .gsData       (gsData),
    .shortFrame   (shortFrame)
  );

  typedef struct {
    string        name;
    logic [4:0]   fc;
    logic [20:0]  bc;
    logic [8:0]   mc;
    logic [335:0] dc;
    logic         valid;
    logic         mism;
    logic         short_f;
    int           pulses;
    logic         chk_gs;
    logic [5:0]   addr;
    logic [15:0]  gs_exp;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic mon_busy = 1'b0;

  task automatic check(input string name, input logic [767:0] act, input logic [767:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  function automatic logic [768:0] ctrl_frame(input logic [4:0] fc, input logic [20:0] bc,
                                              input logic [8:0] mc, input logic [335:0] dc);
    logic [768:0] f;
    f = '0;
    f[768]     = 1'b1;
    f[767:760] = 8'h96;
    f[370:366] = fc;
    f[365:345] = bc;
    f[344:336] = mc;
    f[335:0]   = dc;
    return f;
  endfunction

  function automatic exp_t mk(input string name, input logic [4:0] fc, input logic [20:0] bc,
                              input logic [8:0] mc, input logic [335:0] dc, input logic valid,
                              input logic mism, input logic short_f, input int pulses,
                              input logic chk_gs, input logic [5:0] addr, input logic [15:0] gs_exp);
    exp_t e;
    e.name = name; e.fc = fc; e.bc = bc; e.mc = mc; e.dc = dc;
    e.valid = valid; e.mism = mism; e.short_f = short_f; e.pulses = pulses;
    e.chk_gs = chk_gs; e.addr = addr; e.gs_exp = gs_exp;
    return e;
  endfunction

  task automatic send_bit(input logic b, input logic chk, input logic exp_sout, input int idx);
    ser.SIN = b;
    repeat (3) @(negedge spiClk);
    ser.SCLK = 1'b1;
    repeat (3) @(negedge spiClk);
    if (chk) check($sformatf("sout_edge%0d", idx + 1), 768'(ser.SOUT), 768'(exp_sout));
    ser.SCLK = 1'b0;
  endtask

  task automatic send_frame(input logic [768:0] f);
    for (int i = 768; i >= 0; i--) send_bit(f[i], 1'b0, 1'b0, 0);
  endtask

  task automatic pulse_lat(input exp_t e);
    exp_q.push_back(e);
    @(negedge spiClk);
    ser.LAT = 1'b1;
    repeat (4) @(negedge spiClk);
    ser.LAT = 1'b0;
    repeat (30) @(negedge spiClk);
  endtask

  task automatic check_reset(input string tag);
    repeat (3) @(negedge spiClk);
    check({tag, ".fcOut"},        768'(fcOut), 768'(0));
    check({tag, ".bcOut"},        768'(bcOut), 768'(0));
    check({tag, ".mcOut"},        768'(mcOut), 768'(0));
    check({tag, ".dcOut"},        768'(dcOut), 768'(0));
    check({tag, ".ctrlValid"},    768'(ctrlValid), 768'(0));
    check({tag, ".ctrlMismatch"}, 768'(ctrlMismatch), 768'(0));
    check({tag, ".shortFrame"},   768'(shortFrame), 768'(0));
    check({tag, ".gsStrobe"},     768'(gsStrobe), 768'(0));
    check({tag, ".SOUT"},         768'(ser.SOUT), 768'(0));
    check({tag, ".gsData"},       768'(gsData), 768'(0));
  endtask

  // Monitor: watch each LAT, count gsStrobe pulses, then compare the settled state.
  initial begin
    exp_t e;
    int   pulses;
    gsAddr = 6'd0;
    forever begin
      @(posedge ser.LAT);
      mon_busy = 1'b1;
      pulses = 0;
      repeat (12) begin
        @(negedge spiClk);
        if (gsStrobe) pulses++;
      end
      if (exp_q.size() == 0) begin
        check("unexpected_lat.queue_size", 768'(0), 768'(1));
      end else begin
        e = exp_q.pop_front();
        check({e.name, ".fcOut"},        768'(fcOut), 768'(e.fc));
        check({e.name, ".bcOut"},        768'(bcOut), 768'(e.bc));
        check({e.name, ".mcOut"},        768'(mcOut), 768'(e.mc));
        check({e.name, ".dcOut"},        768'(dcOut), 768'(e.dc));
        check({e.name, ".ctrlValid"},    768'(ctrlValid), 768'(e.valid));
        check({e.name, ".ctrlMismatch"}, 768'(ctrlMismatch), 768'(e.mism));
        check({e.name, ".shortFrame"},   768'(shortFrame), 768'(e.short_f));
        check({e.name, ".gsStrobe_pulses"}, 768'(pulses), 768'(e.pulses));
        if (e.chk_gs) begin
          gsAddr = e.addr;
          @(negedge spiClk);
          check($sformatf("%s.gsData[%0d]", e.name, e.addr), 768'(gsData), 768'(e.gs_exp));
        end
      end
      mon_busy = 1'b0;
    end
  end

  initial begin
    logic [768:0] fa, fb, fgs, fbad, f1, fc3;
    logic         sent [1538];
    logic [335:0] dc127, dc2a;
    logic         b;
    int           wait_cyc;

    ser.SCLK = 1'b0; ser.SIN = 1'b0; ser.LAT = 1'b0;
    dc127 = {48{7'd127}};
    dc2a  = {48{7'h2A}};
    fa  = ctrl_frame(5'b01111, {7'd127, 7'd51, 7'd127}, 9'b001001001, dc127);
    fb  = ctrl_frame(5'b01111, {7'd127, 7'd60, 7'd127}, 9'b001001001, dc127);
    fc3 = ctrl_frame(5'b10101, {7'd1, 7'd2, 7'd3}, 9'b111000101, dc2a);
    fgs = '0;
    for (int n = 0; n < 48; n++) fgs[16*n +: 16] = 16'h0100 + 16'(n);
    fbad = fa;
    fbad[767:760] = 8'h55;

    repeat (5) @(negedge spiClk);
    nReset = 1'b1;
    repeat (10) @(negedge spiClk);
    check_reset("reset");

    // Two identical control frames
    send_frame(fa);
    pulse_lat(mk("ctrl_first", 5'b01111, {7'd127, 7'd51, 7'd127}, 9'b001001001, dc127,
                 1'b0, 1'b0, 1'b0, 0, 1'b0, 6'd0, 16'h0));
    send_frame(fa);
    pulse_lat(mk("ctrl_confirm", 5'b01111, {7'd127, 7'd51, 7'd127}, 9'b001001001, dc127,
                 1'b1, 1'b0, 1'b0, 0, 1'b0, 6'd0, 16'h0));

    // Differing second frame (BCG=60)
    send_frame(fb);
    pulse_lat(mk("ctrl_mismatch", 5'b01111, {7'd127, 7'd60, 7'd127}, 9'b001001001, dc127,
                 1'b0, 1'b1, 1'b0, 0, 1'b0, 6'd0, 16'h0));

    // Grayscale frame, channel n = 0x0100+n
    send_frame(fgs);
    pulse_lat(mk("gs_frame", 5'b01111, {7'd127, 7'd60, 7'd127}, 9'b001001001, dc127,
                 1'b0, 1'b1, 1'b0, 1, 1'b1, 6'd47, 16'h012F));

    // 500-bit short frame
    for (int i = 0; i < 500; i++) send_bit(1'((i % 3) == 0), 1'b0, 1'b0, 0);
    pulse_lat(mk("short_frame", 5'b01111, {7'd127, 7'd60, 7'd127}, 9'b001001001, dc127,
                 1'b0, 1'b1, 1'b1, 0, 1'b1, 6'd47, 16'h012F));

    // Control-mode frame with wrong header is ignored
    send_frame(fbad);
    pulse_lat(mk("bad_header", 5'b01111, {7'd127, 7'd60, 7'd127}, 9'b001001001, dc127,
                 1'b0, 1'b1, 1'b1, 0, 1'b1, 6'd0, 16'h0100));

    // Reset in mid-frame after 300 bits
    for (int i = 0; i < 300; i++) send_bit(1'(i[0]), 1'b0, 1'b0, 0);
    @(negedge spiClk);
    nReset = 1'b0;
    repeat (3) @(negedge spiClk);
    nReset = 1'b1;
    repeat (10) @(negedge spiClk);
    check_reset("reset_midframe");
    send_frame(fa);
    pulse_lat(mk("post_reset_first", 5'b01111, {7'd127, 7'd51, 7'd127}, 9'b001001001, dc127,
                 1'b0, 1'b0, 1'b0, 0, 1'b0, 6'd0, 16'h0));
    send_frame(fa);
    pulse_lat(mk("post_reset_confirm", 5'b01111, {7'd127, 7'd51, 7'd127}, 9'b001001001, dc127,
                 1'b1, 1'b0, 1'b0, 0, 1'b0, 6'd0, 16'h0));

    // 1538 chained bits: random first frame passes through to SOUT
    for (int i = 0; i < 769; i++) f1[i] = 1'($urandom_range(0, 1));
    for (int k = 0; k < 1538; k++) begin
      b = (k < 769) ? f1[768 - k] : fc3[768 - (k - 769)];
      sent[k] = b;
      if (k >= 768) send_bit(b, 1'b1, sent[k - 768], k);
      else          send_bit(b, 1'b0, 1'b0, k);
    end
    pulse_lat(mk("chained_last", 5'b10101, {7'd1, 7'd2, 7'd3}, 9'b111000101, dc2a,
                 1'b0, 1'b1, 1'b0, 0, 1'b0, 6'd0, 16'h0));

    wait_cyc = 0;
    while ((exp_q.size() != 0 || mon_busy) && wait_cyc < 200) begin
      @(negedge spiClk);
      wait_cyc++;
    end
    if (wait_cyc >= 200) check("scoreboard_drain.pending", 768'(exp_q.size()), 768'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
